id_issue_ctrl: RTL and testbench

Decode-stage issue controller for the RISC-V pipeline. It owns the IF/ID instruction register and classifies the held instruction's immediate format for the immediate generator. It issues instructions to execute under a valid/ready handshake, inserts a bubble on load-use hazards, and squashes and blocks fetch for a programmable number of cycles after a taken branch.

---
 rtl/id_pkg.sv | 31 +++
 rtl/id_hazard_det.sv | 25 ++
 rtl/id_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_id_issue_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared types, opcodes and immediate-format decode for the decode-stage issue controller.
package id_pkg;

   typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_B} imm_fmt_t;
   typedef enum logic [1:0] {ST_RUN, ST_BUBBLE, ST_FLUSH} id_state_t;

   localparam int unsigned INST_W = 32;
   localparam int unsigned OPC_W  = 7;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned FCNT_W = 4;
   localparam int unsigned PERF_W = 16;

   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;

   // Immediate format needed by the immediate generator for a given opcode
   function automatic imm_fmt_t imm_fmt_of(input logic [OPC_W-1:0] opcode);
      imm_fmt_t fmt;
      case (opcode)
         OP_LOAD, OP_IMM: fmt = IMM_I;
         OP_STORE:        fmt = IMM_S;
         OP_BRANCH:       fmt = IMM_B;
         default:         fmt = IMM_NONE;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/id_hazard_det.sv
// Load-use hazard detector: opcode-based source-register use decode plus compare against the load in EX.
module id_hazard_det
   import id_pkg::*;
(
   input  logic             hold_valid,
   input  logic [OPC_W-1:0] opcode,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   output logic             hazard_c
);

   logic uses_rs1;
   logic uses_rs2;

   always_comb begin
      uses_rs1 = opcode inside {OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_REG};
      uses_rs2 = opcode inside {OP_STORE, OP_BRANCH, OP_REG};
      // x0 is never a real dependency
      hazard_c = hold_valid & ex_mem_read & (ex_rd != REG_W'(0)) &
                 ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));
   end

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: IF/ID hold register, load-use bubble and post-branch flush.
// Optional build macro ID_PERF_CNT_EN adds the stall_cnt performance counter.
module id_issue_ctrl
   import id_pkg::*;
#(
   parameter int unsigned PC_W      = 32,
   parameter int unsigned FLUSH_CYC = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_valid,
   input  logic [INST_W-1:0] if_inst,
   input  logic [PC_W-1:0]   if_pc,
   output logic              if_ready,
   output logic              id_valid,
   output logic [INST_W-1:0] id_inst,
   output logic [PC_W-1:0]   id_pc,
   output logic [1:0]        id_imm_fmt,
   input  logic              id_ready,
   input  logic              ex_mem_read,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              branch_taken
`ifdef ID_PERF_CNT_EN
  ,output logic [PERF_W-1:0] stall_cnt
`endif
);

   localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYC - 1);

   id_state_t          state_q, state_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic               hold_valid_q;
   logic [INST_W-1:0]  hold_inst_q;
   logic [PC_W-1:0]    hold_pc_q;
   imm_fmt_t           hold_fmt_q;
   logic               hazard_c;
   logic               fire_c;
   logic               capture_c;

   id_hazard_det u_hazard (
      .hold_valid  (hold_valid_q),
      .opcode      (hold_inst_q[6:0]),
      .rs1         (hold_inst_q[19:15]),
      .rs2         (hold_inst_q[24:20]),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .hazard_c    (hazard_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Next state plus the handshake outputs; branch beats hazard beats normal issue
   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      id_valid = 1'b0;
      if_ready = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (branch_taken) begin
               state_d = ST_FLUSH;
               fcnt_d  = FLUSH_LOAD;
            end else if (hazard_c) begin
               state_d = ST_BUBBLE;
            end else begin
               id_valid = hold_valid_q;
               if_ready = ~hold_valid_q | id_ready;
            end
         end
         ST_BUBBLE: begin
            if (branch_taken) begin
               state_d = ST_FLUSH;
               fcnt_d  = FLUSH_LOAD;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (branch_taken) begin
               fcnt_d = FLUSH_LOAD;
            end else if (fcnt_q == FCNT_W'(0)) begin
               state_d = ST_RUN;
            end else begin
               fcnt_d = fcnt_q - FCNT_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   assign fire_c    = id_valid & id_ready;
   assign capture_c = if_valid & if_ready;

   // Capture overrides the issue-clear so fire+capture is a gapless replacement
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid_q <= 1'b0;
         hold_inst_q  <= '0;
         hold_pc_q    <= '0;
         hold_fmt_q   <= IMM_NONE;
      end else if (capture_c) begin
         hold_valid_q <= 1'b1;
         hold_inst_q  <= if_inst;
         hold_pc_q    <= if_pc;
         hold_fmt_q   <= imm_fmt_of(if_inst[6:0]);
      end else if (branch_taken || fire_c) begin
         hold_valid_q <= 1'b0;
      end
   end

   assign id_inst    = hold_inst_q;
   assign id_pc      = hold_pc_q;
   assign id_imm_fmt = hold_fmt_q;

`ifdef ID_PERF_CNT_EN
   logic [PERF_W-1:0] stall_q;
   logic              stall_inc_c;

   assign stall_inc_c = (state_q != ST_RUN) | (hold_valid_q & ~id_ready);

   // Saturating stall counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= '0;
      end else if (stall_inc_c && (stall_q != {PERF_W{1'b1}})) begin
         stall_q <= stall_q + PERF_W'(1);
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed self-checking bench for id_issue_ctrl (FLUSH_CYC=3); stall_cnt checked when ID_PERF_CNT_EN is set.
module tb_id_issue_ctrl;

   localparam int unsigned PC_W = 32;

   localparam logic [31:0] I_ADDI   = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] I_SW     = 32'h0011_2023; // sw x1,0(x2)
   localparam logic [31:0] I_BEQ    = 32'h0020_8463; // beq x1,x2,8
   localparam logic [31:0] I_ADD    = 32'h0072_8333; // add x6,x5,x7
   localparam logic [31:0] I_LUI    = 32'h0000_10B7; // lui x1,1
   localparam logic [31:0] I_ADDIX3 = 32'h0010_0193; // addi x3,x0,1

   logic            clk = 1'b0;
   logic            reset_n;
   logic            if_valid;
   logic [31:0]     if_inst;
   logic [PC_W-1:0] if_pc;
   logic            if_ready;
   logic            id_valid;
   logic [31:0]     id_inst;
   logic [PC_W-1:0] id_pc;
   logic [1:0]      id_imm_fmt;
   logic            id_ready;
   logic            ex_mem_read;
   logic [4:0]      ex_rd;
   logic            branch_taken;
`ifdef ID_PERF_CNT_EN
   logic [15:0]     stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_issue_ctrl #(.PC_W(PC_W), .FLUSH_CYC(3)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .if_valid     (if_valid),
      .if_inst      (if_inst),
      .if_pc        (if_pc),
      .if_ready     (if_ready),
      .id_valid     (id_valid),
      .id_inst      (id_inst),
      .id_pc        (id_pc),
      .id_imm_fmt   (id_imm_fmt),
      .id_ready     (id_ready),
      .ex_mem_read  (ex_mem_read),
      .ex_rd        (ex_rd),
      .branch_taken (branch_taken)
`ifdef ID_PERF_CNT_EN
     ,.stall_cnt    (stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after input changes
   task automatic settle();
      #1;
   endtask

   initial begin
      reset_n = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0;
      id_ready = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; branch_taken = 1'b0;
      #2;
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      chk("rst_if_ready", 64'(if_ready), 64'd1);
      chk("rst_id_inst", 64'(id_inst), 64'd0);
      chk("rst_id_pc", 64'(id_pc), 64'd0);
      chk("rst_fmt", 64'(id_imm_fmt), 64'd0);
`ifdef ID_PERF_CNT_EN
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Stream: addi then sw, back to back
      if_valid = 1'b1; if_inst = I_ADDI; if_pc = 32'h100; id_ready = 1'b1; settle();
      chk("s0_if_ready", 64'(if_ready), 64'd1);
      chk("s0_id_valid", 64'(id_valid), 64'd0);
      tick();
      if_inst = I_SW; if_pc = 32'h104; settle();
      chk("s1_id_valid", 64'(id_valid), 64'd1);
      chk("s1_id_inst", 64'(id_inst), 64'(I_ADDI));
      chk("s1_id_pc", 64'(id_pc), 64'h100);
      chk("s1_fmt_i", 64'(id_imm_fmt), 64'd1);
      chk("s1_if_ready", 64'(if_ready), 64'd1);
      tick();
      if_valid = 1'b0; settle();
      chk("s2_id_valid", 64'(id_valid), 64'd1);
      chk("s2_id_inst", 64'(id_inst), 64'(I_SW));
      chk("s2_fmt_s", 64'(id_imm_fmt), 64'd2);
      tick();

      // Backpressure: empty register accepts with id_ready=0, then 3 stalled cycles
      id_ready = 1'b0; if_valid = 1'b1; if_inst = I_BEQ; if_pc = 32'h108; settle();
      chk("b0_if_ready_empty", 64'(if_ready), 64'd1);
      chk("b0_id_valid", 64'(id_valid), 64'd0);
      tick();
      if_inst = I_ADD; if_pc = 32'h10C;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_id_valid", 64'(id_valid), 64'd1);
         chk("bp_if_ready", 64'(if_ready), 64'd0);
         chk("bp_id_inst", 64'(id_inst), 64'(I_BEQ));
         chk("bp_fmt_b", 64'(id_imm_fmt), 64'd3);
         tick();
      end
      id_ready = 1'b1; settle();
      chk("b4_id_valid", 64'(id_valid), 64'd1);
      chk("b4_if_ready", 64'(if_ready), 64'd1);
`ifdef ID_PERF_CNT_EN
      chk("b4_stall_cnt", 64'(stall_cnt), 64'd3);
`endif
      tick();

      // Load-use: add x6,x5,x7 held while EX has a load to x5
      ex_mem_read = 1'b1; ex_rd = 5'd5; if_inst = I_LUI; if_pc = 32'h110; settle();
      chk("l0_id_valid", 64'(id_valid), 64'd0);
      chk("l0_if_ready", 64'(if_ready), 64'd0);
      chk("l0_id_inst", 64'(id_inst), 64'(I_ADD));
      tick();
      ex_mem_read = 1'b0; ex_rd = 5'd0; settle();
      chk("l1_bubble_id_valid", 64'(id_valid), 64'd0);
      chk("l1_bubble_if_ready", 64'(if_ready), 64'd0);
      tick();
      settle();
      chk("l2_id_valid", 64'(id_valid), 64'd1);
      chk("l2_id_inst", 64'(id_inst), 64'(I_ADD));
      chk("l2_id_pc", 64'(id_pc), 64'h10C);
      chk("l2_if_ready", 64'(if_ready), 64'd1);
      tick();
      if_inst = I_ADDIX3; if_pc = 32'h114; settle();
      chk("l3_id_inst", 64'(id_inst), 64'(I_LUI));
      chk("l3_fmt_none", 64'(id_imm_fmt), 64'd0);
      chk("l3_id_valid", 64'(id_valid), 64'd1);
      tick();

      // x0 destination of a load never stalls
      if_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd0; settle();
      chk("x0_id_valid", 64'(id_valid), 64'd1);
      chk("x0_if_ready", 64'(if_ready), 64'd1);
      chk("x0_id_inst", 64'(id_inst), 64'(I_ADDIX3));
`ifdef ID_PERF_CNT_EN
      chk("x0_stall_cnt", 64'(stall_cnt), 64'd4);
`endif
      tick();

      // Flush: branch in cycle F1, if_ready back after 3 blocked cycles
      ex_mem_read = 1'b0; if_valid = 1'b1; if_inst = I_SW; if_pc = 32'h118; settle();
      chk("f0_if_ready", 64'(if_ready), 64'd1);
      tick();
      branch_taken = 1'b1; settle();
      chk("f1_if_ready", 64'(if_ready), 64'd0);
      chk("f1_id_valid_squash", 64'(id_valid), 64'd0);
      tick();
      branch_taken = 1'b0; if_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("flush_if_ready", 64'(if_ready), 64'd0);
         chk("flush_id_valid", 64'(id_valid), 64'd0);
         tick();
      end
      settle();
      chk("f5_if_ready", 64'(if_ready), 64'd1);
      chk("f5_id_valid", 64'(id_valid), 64'd0);
`ifdef ID_PERF_CNT_EN
      chk("f5_stall_cnt", 64'(stall_cnt), 64'd7);
`endif
      tick();

      // Repeated branch inside FLUSH reloads the counter
      branch_taken = 1'b1; tick();
      branch_taken = 1'b0; settle();
      chk("r1_if_ready", 64'(if_ready), 64'd0);
      tick();
      branch_taken = 1'b1; tick();
      branch_taken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("reload_if_ready", 64'(if_ready), 64'd0);
         tick();
      end
      settle();
      chk("r6_if_ready", 64'(if_ready), 64'd1);
      tick();

      // Reset asserted in the second FLUSH cycle
      if_valid = 1'b1; if_inst = I_ADDI; if_pc = 32'h200; tick();
      if_valid = 1'b0; branch_taken = 1'b1; tick();
      branch_taken = 1'b0; tick();
      #2;
      reset_n = 1'b0; settle();
      chk("mrst_id_valid", 64'(id_valid), 64'd0);
      chk("mrst_if_ready", 64'(if_ready), 64'd1);
      chk("mrst_id_inst", 64'(id_inst), 64'd0);
      #1;
      reset_n = 1'b1;
      tick();
      settle();
      chk("mrst_run_if_ready", 64'(if_ready), 64'd1);
      chk("mrst_run_id_valid", 64'(id_valid), 64'd0);
`ifdef ID_PERF_CNT_EN
      chk("mrst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
